// File: rtl/fifo_wptr_full.sv
// Write-domain side of the async FIFO: binary/Gray write pointer, RAM write
// port, and full / almost-full / level / overflow status against the synced read pointer.
module fifo_wptr_full #(
   parameter int ADDR_W    = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              winc,
   input  logic [ADDR_W:0]   rptr_sync,
   input  logic              ovf_clr,
   output logic              wen,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W:0]   wptr,
   output logic              wfull,
   output logic              walmost_full,
   output logic [ADDR_W:0]   wlevel,
   output logic              woverflow
);

   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

   logic [ADDR_W:0] wbin_q, wbin_d;
   logic [ADDR_W:0] wptr_q, wptr_d;
   logic [ADDR_W:0] wlevel_q, wlevel_d;
   logic [ADDR_W:0] rbin;
   logic            wfull_q, wfull_d;
   logic            waf_q, waf_d;
   logic            wovf_q, wovf_d;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i <= ADDR_W; i++) begin : g_rbin
      assign rbin[i] = ^(rptr_sync >> i);
   end

   assign wen = winc & ~wfull_q;

   always_comb begin
      wbin_d   = wbin_q + (ADDR_W + 1)'(wen);
      wptr_d   = (wbin_d >> 1) ^ wbin_d;
      wfull_d  = (wptr_d == {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]});
      wlevel_d = wbin_d - rbin;
      waf_d    = (wlevel_d >= AF_THRESH);
      wovf_d   = (winc & wfull_q) | (wovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wbin_q   <= '0;
         wptr_q   <= '0;
         wlevel_q <= '0;
         wfull_q  <= 1'b0;
         waf_q    <= 1'b0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wptr_q   <= wptr_d;
         wlevel_q <= wlevel_d;
         wfull_q  <= wfull_d;
         waf_q    <= waf_d;
         wovf_q   <= wovf_d;
      end
   end

   assign waddr        = wbin_q[ADDR_W-1:0];
   assign wptr         = wptr_q;
   assign wfull        = wfull_q;
   assign walmost_full = waf_q;
   assign wlevel       = wlevel_q;
   assign woverflow    = wovf_q;

endmodule
